fb_access_arbiter: RTL and testbench

//  Shares the single-access frame buffer between the host pixel-write port and the

---
 rtl/fb_pkg.sv | 33 +++
 rtl/fb_access_arbiter_fifo.sv | 81 ++++++++
 rtl/fb_access_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame buffer access path: bus widths, default
// raster geometry and arbitration limit, the pixel tag carried from the
// buffer read to the palette stage, and a wrapping address increment.
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_ADDR_W   = 13;
    localparam int FB_COLOUR_W = 2;

    localparam int DEF_H_PIXELS      = 128;
    localparam int DEF_V_LINES       = 64;
    localparam int DEF_HOST_MAX_WAIT = 4;

    // One scanout pixel as it travels from the buffer to the palette.
    typedef struct packed {
        logic [FB_COLOUR_W-1:0] colour;
        logic                   sof;
        logic                   eol;
    } px_tag_t;

    localparam int PX_TAG_W = $bits(px_tag_t);

    // Increment that returns to zero after reaching 'last'.
    function automatic logic [FB_ADDR_W-1:0] wrap_inc(
        input logic [FB_ADDR_W-1:0] value,
        input logic [FB_ADDR_W-1:0] last
    );
        return (value == last) ? '0 : value + 1'b1;
    endfunction

endpackage

// File: rtl/fb_access_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// fb_skid_fifo
// Two-entry FIFO of pixel tags between the frame buffer read port and the
// palette stage. Push and pop may happen in the same cycle. The head is
// exposed as a valid/ready stream and reads as zero while empty.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push        write push_data this cycle (caller guarantees room)
//   push_data   packed px_tag_t
//   head_valid  FIFO not empty
//   head_ready  consumer takes the head this cycle when head_valid
//   head_data   packed px_tag_t at the head, zero when empty
//   count       current occupancy, 0..2
// ---------------------------------------------------------------------------
module fb_skid_fifo
    import fb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [PX_TAG_W-1:0] push_data,
    output logic                head_valid,
    input  logic                head_ready,
    output logic [PX_TAG_W-1:0] head_data,
    output logic [1:0]          count
);

    logic [PX_TAG_W-1:0] mem_q [2];
    logic [PX_TAG_W-1:0] mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                pop;

    assign head_valid = (count_q != 2'd0);
    assign pop        = head_valid && head_ready;
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is not reset; it is only observable through head_data, which is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// fb_access_arbiter
// Shares the single-port frame buffer between host pixel writes and raster
// scanout reads. Each cycle at most one access is granted. Scanout reads are
// credit limited so the two-entry skid FIFO can never overflow; a host write
// that keeps losing to scanout is forced through after HOST_MAX_WAIT cycles.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   wr_req       host write request, wr_addr/wr_colour held until wr_ack
//   wr_addr      host pixel address
//   wr_colour    host pixel colour
//   wr_ack       host write accepted this cycle (also for out-of-range addresses)
//   scan_en      allow new scanout reads
//   fb_addr      buffer write address (zero unless a host write is granted)
//   fb_colour    buffer write data    (zero unless a host write is granted)
//   fb_ie_n      buffer write strobe, active low
//   fb_rd_addr   buffer read address (current scan address)
//   fb_oe        buffer read enable
//   fb_rd_data   buffer read data, valid the cycle after fb_oe
//   px_valid     pixel stream valid
//   px_ready     pixel stream ready
//   px_colour    pixel colour
//   px_sof       pixel is address 0
//   px_eol       pixel is the last of its line
//   frame_done   one-cycle pulse after the last pixel of a frame is handed off
// ---------------------------------------------------------------------------
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int H_PIXELS      = DEF_H_PIXELS,
    parameter int V_LINES       = DEF_V_LINES,
    parameter int HOST_MAX_WAIT = DEF_HOST_MAX_WAIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic [FB_ADDR_W-1:0]   wr_addr,
    input  logic [FB_COLOUR_W-1:0] wr_colour,
    output logic                   wr_ack,
    input  logic                   scan_en,
    output logic [FB_ADDR_W-1:0]   fb_addr,
    output logic [FB_COLOUR_W-1:0] fb_colour,
    output logic                   fb_ie_n,
    output logic [FB_ADDR_W-1:0]   fb_rd_addr,
    output logic                   fb_oe,
    input  logic [FB_COLOUR_W-1:0] fb_rd_data,
    output logic                   px_valid,
    input  logic                   px_ready,
    output logic [FB_COLOUR_W-1:0] px_colour,
    output logic                   px_sof,
    output logic                   px_eol,
    output logic                   frame_done
);

    localparam int                   FB_SIZE     = H_PIXELS * V_LINES;
    localparam logic [FB_ADDR_W:0]   FB_SIZE_EXT = (FB_ADDR_W + 1)'(FB_SIZE);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR   = FB_ADDR_W'(FB_SIZE - 1);
    localparam logic [FB_ADDR_W-1:0] LAST_COL    = FB_ADDR_W'(H_PIXELS - 1);
    localparam int                   WAIT_W      = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_MAX    = WAIT_W'(HOST_MAX_WAIT);

    // Scan position: linear address plus column so eol needs no divider.
    logic [FB_ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [FB_ADDR_W-1:0] scan_col_q,  scan_col_d;
    logic [WAIT_W-1:0]    wait_cnt_q,  wait_cnt_d;
    // Read issued last cycle whose data arrives on fb_rd_data now.
    logic                 inflight_q,     inflight_d;
    logic                 inflight_sof_q, inflight_sof_d;
    logic                 inflight_eol_q, inflight_eol_d;
    // Address of the next pixel to be handed off, used to spot end of frame.
    logic [FB_ADDR_W-1:0] out_addr_q, out_addr_d;
    logic                 frame_done_q, frame_done_d;

    logic                 scan_cand, host_cand;
    logic                 scan_grant, host_grant;
    logic [2:0]           in_use;
    logic [1:0]           fifo_count;
    logic                 px_pop;
    px_tag_t              push_tag, head_tag;
    logic [PX_TAG_W-1:0]  head_bits;

    // ---------------- arbitration ----------------
    always_comb begin
        px_pop = px_valid && px_ready;
        // Entries still claimed after this cycle's handoff; counting the pop
        // lets scanout sustain one read per cycle while the palette keeps up.
        in_use = 3'(fifo_count) + 3'(inflight_q) - 3'(px_pop);
        // Grants are masked during reset because the access outputs are
        // combinational from the request inputs.
        scan_cand  = !rst && scan_en && (in_use < 3'd2);
        host_cand  = !rst && wr_req;
        host_grant = host_cand && (!scan_cand || (wait_cnt_q >= WAIT_MAX));
        scan_grant = scan_cand && !host_grant;
    end

    // ---------------- buffer access outputs ----------------
    always_comb begin
        wr_ack     = host_grant;
        fb_addr    = host_grant ? wr_addr   : '0;
        fb_colour  = host_grant ? wr_colour : '0;
        // Out-of-range writes are acknowledged and silently dropped.
        fb_ie_n    = !(host_grant && ({1'b0, wr_addr} < FB_SIZE_EXT));
        fb_oe      = scan_grant;
        fb_rd_addr = scan_addr_q;
    end

    // ---------------- next state ----------------
    always_comb begin
        scan_addr_d    = scan_addr_q;
        scan_col_d     = scan_col_q;
        wait_cnt_d     = wait_cnt_q;
        inflight_d     = scan_grant;
        inflight_sof_d = inflight_sof_q;
        inflight_eol_d = inflight_eol_q;
        out_addr_d     = out_addr_q;
        frame_done_d   = 1'b0;

        if (host_grant) begin
            wait_cnt_d = '0;
        end else if (wr_req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (scan_grant) begin
            inflight_sof_d = (scan_addr_q == '0);
            inflight_eol_d = (scan_col_q == LAST_COL);
            scan_addr_d    = wrap_inc(scan_addr_q, LAST_ADDR);
            scan_col_d     = wrap_inc(scan_col_q, LAST_COL);
        end

        if (px_pop) begin
            out_addr_d   = wrap_inc(out_addr_q, LAST_ADDR);
            frame_done_d = (out_addr_q == LAST_ADDR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_addr_q    <= '0;
            scan_col_q     <= '0;
            wait_cnt_q     <= '0;
            inflight_q     <= 1'b0;
            inflight_sof_q <= 1'b0;
            inflight_eol_q <= 1'b0;
            out_addr_q     <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            scan_addr_q    <= scan_addr_d;
            scan_col_q     <= scan_col_d;
            wait_cnt_q     <= wait_cnt_d;
            inflight_q     <= inflight_d;
            inflight_sof_q <= inflight_sof_d;
            inflight_eol_q <= inflight_eol_d;
            out_addr_q     <= out_addr_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // ---------------- pixel path ----------------
    always_comb begin
        push_tag.colour = fb_rd_data;
        push_tag.sof    = inflight_sof_q;
        push_tag.eol    = inflight_eol_q;
        head_tag        = px_tag_t'(head_bits);
    end

    fb_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (push_tag),
        .head_valid (px_valid),
        .head_ready (px_ready),
        .head_data  (head_bits),
        .count      (fifo_count)
    );

    assign px_colour  = head_tag.colour;
    assign px_sof     = head_tag.sof;
    assign px_eol     = head_tag.eol;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_access_arbiter
// Bench for fb_access_arbiter with a synchronous frame buffer model. A
// scoreboard predicts the pixel stream from the raster order and the writes
// the bench itself issued; scenario tasks check arbitration and boundaries.
// A second instance with 64-pixel lines covers the out-of-range write case.
// ---------------------------------------------------------------------------
module tb_fb_access_arbiter;

    localparam int H    = 128;
    localparam int V    = 64;
    localparam int SIZE = H * V;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [12:0] wr_addr;
    logic [1:0]  wr_colour;
    logic        scan_en;
    logic        px_ready;
    logic [1:0]  fb_rd_data = 2'd0;

    logic        wr_ack, fb_ie_n, fb_oe, px_valid, px_sof, px_eol, frame_done;
    logic [12:0] fb_addr, fb_rd_addr;
    logic [1:0]  fb_colour, px_colour;

    logic        s_wr_ack, s_fb_ie_n, s_fb_oe, s_px_valid, s_px_sof, s_px_eol, s_frame_done;
    logic [12:0] s_fb_addr, s_fb_rd_addr;
    logic [1:0]  s_fb_colour, s_px_colour;

    int checks   = 0;
    int failures = 0;

    fb_access_arbiter #(.H_PIXELS(H), .V_LINES(V), .HOST_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_colour(wr_colour),
        .wr_ack(wr_ack), .scan_en(scan_en), .fb_addr(fb_addr), .fb_colour(fb_colour),
        .fb_ie_n(fb_ie_n), .fb_rd_addr(fb_rd_addr), .fb_oe(fb_oe), .fb_rd_data(fb_rd_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_colour(px_colour), .px_sof(px_sof),
        .px_eol(px_eol), .frame_done(frame_done)
    );

    fb_access_arbiter #(.H_PIXELS(64), .V_LINES(V), .HOST_MAX_WAIT(MAXW)) dut_small (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_colour(wr_colour),
        .wr_ack(s_wr_ack), .scan_en(scan_en), .fb_addr(s_fb_addr), .fb_colour(s_fb_colour),
        .fb_ie_n(s_fb_ie_n), .fb_rd_addr(s_fb_rd_addr), .fb_oe(s_fb_oe), .fb_rd_data(fb_rd_data),
        .px_valid(s_px_valid), .px_ready(px_ready), .px_colour(s_px_colour), .px_sof(s_px_sof),
        .px_eol(s_px_eol), .frame_done(s_frame_done)
    );

    always #5 clk = ~clk;

    // Frame buffer model driven by the DUT's strobes.
    logic [1:0] fb_mem [SIZE];
    always @(posedge clk) begin
        if (!fb_ie_n) fb_mem[fb_addr] <= fb_colour;
        if (fb_oe)    fb_rd_data      <= fb_mem[fb_rd_addr];
    end

    // Reference image: what the bench intends the buffer to hold.
    logic [1:0] ref_mem [SIZE];

    // ---------------- scoreboard ----------------
    typedef struct {
        int         addr;
        logic [1:0] colour;
    } exp_px_t;

    exp_px_t    exp_q[$];
    int         exp_rd_addr = 0;
    bit         exp_fd      = 1'b0;
    bit         hold_prev   = 1'b0;
    logic [3:0] prev_px     = 4'd0;
    int         px5_colour  = -1;
    int         handoffs    = 0;

    always @(negedge clk) begin
        exp_px_t e;
        if (rst) begin
            exp_q.delete();
            exp_rd_addr = 0;
            exp_fd      = 1'b0;
            hold_prev   = 1'b0;
        end else begin
            checks++;
            if (frame_done !== exp_fd) begin
                failures++;
                $display("FAIL frame_done: got %b expected %b at %0t", frame_done, exp_fd, $time);
            end
            exp_fd = 1'b0;

            checks++;
            if (fb_oe && !fb_ie_n) begin
                failures++;
                $display("FAIL one_access: read and write both active at %0t", $time);
            end

            if (wr_ack && (int'(wr_addr) < SIZE)) ref_mem[wr_addr] = wr_colour;

            if (fb_oe) begin
                checks++;
                if (int'(fb_rd_addr) !== exp_rd_addr) begin
                    failures++;
                    $display("FAIL scan_addr: got %0d expected %0d", fb_rd_addr, exp_rd_addr);
                end
                e.addr   = exp_rd_addr;
                e.colour = ref_mem[exp_rd_addr];
                exp_q.push_back(e);
                exp_rd_addr = (exp_rd_addr + 1) % SIZE;
            end

            if (hold_prev) begin
                checks++;
                if ({px_valid, px_colour, px_sof, px_eol} !== {1'b1, prev_px}) begin
                    failures++;
                    $display("FAIL px_hold: got %b expected %b", {px_valid, px_colour, px_sof, px_eol}, {1'b1, prev_px});
                end
            end

            if (px_valid && px_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL px_extra: pixel handed off with none expected");
                end else begin
                    e = exp_q.pop_front();
                    if ({px_colour, px_sof, px_eol} !== {e.colour, e.addr == 0, (e.addr % H) == H - 1}) begin
                        failures++;
                        $display("FAIL px_data addr %0d: got c=%0d sof=%b eol=%b expected c=%0d sof=%b eol=%b",
                                 e.addr, px_colour, px_sof, px_eol, e.colour, e.addr == 0, (e.addr % H) == H - 1);
                    end
                    if (e.addr == SIZE - 1) exp_fd = 1'b1;
                    if (e.addr == 5) px5_colour = int'(px_colour);
                    handoffs++;
                end
            end

            hold_prev = px_valid && !px_ready;
            prev_px   = {px_colour, px_sof, px_eol};
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        wr_req   = 1'b0;
        scan_en  = 1'b0;
        px_ready = 1'b1;
        repeat (6) step();
    endtask

    localparam logic [36:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 13'd0, 2'd0, 13'd0, 1'b0, 2'd0, 3'b000};

    function automatic logic [36:0] out_vec();
        return {wr_ack, fb_ie_n, fb_oe, fb_addr, fb_colour, fb_rd_addr,
                px_valid, px_colour, px_sof, px_eol, frame_done};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 13'd77;
        scan_en = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", out_vec(), RESET_VEC);
        end
        wr_req   = 1'b0;
        scan_en  = 1'b0;
        px_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        int eols = 0;
        int fds  = 0;
        int fd_cyc = -1;
        scan_en  = 1'b1;
        px_ready = 1'b1;
        for (int cyc = 0; cyc <= SIZE + 2; cyc++) begin
            @(negedge clk);
            if (cyc < 2) begin
                checks++;
                if (px_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL start_latency: px_valid=%b at cycle %0d expected 0", px_valid, cyc);
                end
            end else if (cyc < SIZE + 2) begin
                checks++;
                if ({px_valid, px_colour} !== {1'b1, 2'(cyc - 2)}) begin
                    failures++;
                    $display("FAIL stream cycle %0d: got v=%b c=%0d expected v=1 c=%0d", cyc, px_valid, px_colour, (cyc - 2) % 4);
                end
                if (px_valid && px_eol) eols++;
            end
            if (frame_done) begin
                fds++;
                fd_cyc = cyc;
            end
            step();
        end
        checks++;
        if (eols !== V) begin
            failures++;
            $display("FAIL eol_count: got %0d expected %0d", eols, V);
        end
        checks++;
        if (fds !== 1 || fd_cyc !== SIZE + 2) begin
            failures++;
            $display("FAIL frame_done_count: got %0d pulses at cycle %0d expected 1 at %0d", fds, fd_cyc, SIZE + 2);
        end
        drain();
    endtask

    task automatic test_host_wait();
        int ack_at = -1;
        int reads  = 0;
        logic [12:0] a;
        logic [1:0]  c;
        scan_en  = 1'b1;
        px_ready = 1'b1;
        repeat (4) step();
        a = 13'($urandom_range(0, SIZE - 1));
        c = 2'($urandom);
        wr_req    = 1'b1;
        wr_addr   = a;
        wr_colour = c;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (wr_ack) begin
                ack_at = n;
                checks++;
                if ({fb_ie_n, fb_addr, fb_colour, fb_oe} !== {1'b0, a, c, 1'b0}) begin
                    failures++;
                    $display("FAIL forced_write: got ie_n=%b addr=%0d c=%0d oe=%b expected 0/%0d/%0d/0",
                             fb_ie_n, fb_addr, fb_colour, fb_oe, a, c);
                end
                break;
            end
            if (fb_oe) reads++;
            step();
        end
        step();
        wr_req = 1'b0;
        checks++;
        if (ack_at !== MAXW + 1) begin
            failures++;
            $display("FAIL host_wait: ack on request cycle %0d expected %0d", ack_at, MAXW + 1);
        end
        checks++;
        if (reads !== MAXW) begin
            failures++;
            $display("FAIL host_wait_reads: got %0d reads expected %0d", reads, MAXW);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int reads = 0;
        int acks  = 0;
        int h0;
        px_ready  = 1'b0;
        scan_en   = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 13'($urandom_range(0, SIZE - 1));
        wr_colour = 2'($urandom);
        h0 = handoffs;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (fb_oe)  reads++;
            if (wr_ack) acks++;
            step();
            if (acks > 0 && wr_ack === 1'b0) begin end
            wr_addr   = 13'($urandom_range(0, SIZE - 1));
            wr_colour = 2'($urandom);
        end
        wr_req = 1'b0;
        checks++;
        if (reads !== 2) begin
            failures++;
            $display("FAIL stall_reads: got %0d expected 2", reads);
        end
        checks++;
        if (acks !== 8) begin
            failures++;
            $display("FAIL stall_acks: got %0d expected 8", acks);
        end
        px_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (fb_oe) reads++;
            step();
        end
        scan_en = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (fb_oe) reads++;
            step();
        end
        @(negedge clk);
        checks++;
        if ((handoffs - h0) !== reads || px_valid !== 1'b0) begin
            failures++;
            $display("FAIL resume: handed off %0d pixels for %0d reads, px_valid=%b", handoffs - h0, reads, px_valid);
        end
        drain();
    endtask

    task automatic test_out_of_range();
        wr_req    = 1'b1;
        wr_addr   = 13'd8191;
        wr_colour = 2'($urandom);
        @(negedge clk);
        checks++;
        if ({wr_ack, fb_ie_n, fb_addr, s_wr_ack, s_fb_ie_n} !== {1'b1, 1'b0, 13'd8191, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL addr_8191: got ack=%b ie_n=%b addr=%0d small ack=%b ie_n=%b expected 1/0/8191 small 1/1",
                     wr_ack, fb_ie_n, fb_addr, s_wr_ack, s_fb_ie_n);
        end
        step();
        wr_addr = 13'd4096;
        @(negedge clk);
        checks++;
        if ({wr_ack, fb_ie_n, s_wr_ack, s_fb_ie_n} !== 4'b1011) begin
            failures++;
            $display("FAIL addr_4096: got ack=%b ie_n=%b small ack=%b ie_n=%b expected 1/0 small 1/1",
                     wr_ack, fb_ie_n, s_wr_ack, s_fb_ie_n);
        end
        step();
        wr_addr = 13'd4095;
        @(negedge clk);
        checks++;
        if ({s_wr_ack, s_fb_ie_n, s_fb_addr} !== {1'b1, 1'b0, 13'd4095}) begin
            failures++;
            $display("FAIL small_last_addr: got ack=%b ie_n=%b addr=%0d expected 1/0/4095", s_wr_ack, s_fb_ie_n, s_fb_addr);
        end
        step();
        drain();
    endtask

    task automatic test_mid_reset();
        int got = 0;
        scan_en  = 1'b1;
        px_ready = 1'b0;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (px_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_setup: px_valid=%b expected 1", px_valid);
        end
        step();
        rst    = 1'b1;
        wr_req = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h expected %h", out_vec(), RESET_VEC);
        end
        step();
        wr_req   = 1'b0;
        px_ready = 1'b1;
        rst      = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (px_valid) begin
                got = 1;
                checks++;
                if ({px_sof, px_colour} !== {1'b1, ref_mem[0]}) begin
                    failures++;
                    $display("FAIL first_after_reset: got sof=%b c=%0d expected sof=1 c=%0d", px_sof, px_colour, ref_mem[0]);
                end
                break;
            end
            step();
        end
        if (got == 0) begin
            checks++;
            failures++;
            $display("FAIL first_after_reset: no pixel within 10 cycles");
        end
        step();
        drain();
    endtask

    task automatic test_write_ahead();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        px5_colour = -1;
        wr_req    = 1'b1;
        wr_addr   = 13'd5;
        wr_colour = 2'd0;
        step();
        wr_req  = 1'b0;
        scan_en = 1'b1;
        repeat (3) step();
        scan_en = 1'b0;
        @(negedge clk);
        checks++;
        if (fb_rd_addr !== 13'd3) begin
            failures++;
            $display("FAIL scan_held: fb_rd_addr=%0d expected 3", fb_rd_addr);
        end
        step();
        wr_req    = 1'b1;
        wr_addr   = 13'd5;
        wr_colour = 2'd3;
        step();
        wr_req  = 1'b0;
        scan_en = 1'b1;
        for (int n = 0; n < 20 && px5_colour < 0; n++) step();
        checks++;
        if (px5_colour !== 3) begin
            failures++;
            $display("FAIL write_ahead: pixel 5 colour %0d expected 3", px5_colour);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        wr_req    = 1'b0;
        wr_addr   = 13'd0;
        wr_colour = 2'd0;
        scan_en   = 1'b0;
        px_ready  = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            fb_mem[i] <= 2'(i);
            ref_mem[i] = 2'(i);
        end
        test_reset();
        test_stream();
        test_host_wait();
        test_backpressure();
        test_out_of_range();
        test_mid_reset();
        test_write_ahead();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
